locking_rr_arbiter: RTL

Four-input round-robin arbiter with burst locking for the shared 8-bit ready/valid output channel. Once an input wins a beat, it keeps the channel until it sends `last` or until BURST beats have been accepted. Multi-beat packets therefore never interleave on the shared sink. It sits in the same position as the plain round-robin arbiter, between several packet producers and one decoupled consumer.

---
 rtl/locking_rr_arbiter_pkg.sv | 15 +
 rtl/rr_priority_pick.sv | 33 +++
 rtl/locking_rr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/locking_rr_arbiter_pkg.sv
// Shared constants and state encoding for the four-input locking round-robin arbiter.
package locking_rr_arbiter_pkg;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;
    localparam int CW    = $clog2(BURST + 1);
    localparam int IW    = $clog2(N);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: lowest valid index above last_grant, else lowest valid index.
module rr_priority_pick
    import locking_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [IW-1:0] chosen_o,
    output logic          any_o
);

    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;
    logic          hi_found;

    always_comb begin
        lo_idx   = IW'(N - 1);
        hi_idx   = IW'(N - 1);
        hi_found = 1'b0;
        // Walk downward so the last hit is the lowest qualifying index.
        for (int k = N - 1; k >= 0; k--) begin
            if (valid_i[k]) begin
                lo_idx = IW'(k);
            end
            if (valid_i[k] && (IW'(k) > last_grant_i)) begin
                hi_idx   = IW'(k);
                hi_found = 1'b1;
            end
        end
        chosen_o = hi_found ? hi_idx : lo_idx;
        any_o    = |valid_i;
    end

endmodule

// File: rtl/locking_rr_arbiter.sv
// Four-input round-robin arbiter that holds the shared channel for a whole packet,
// up to BURST beats, so multi-beat packets never interleave at the sink.
module locking_rr_arbiter
    import locking_rr_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          io_in_0_valid,
    input  logic [W-1:0]  io_in_0_bits,
    input  logic          io_in_0_last,
    output logic          io_in_0_ready,
    input  logic          io_in_1_valid,
    input  logic [W-1:0]  io_in_1_bits,
    input  logic          io_in_1_last,
    output logic          io_in_1_ready,
    input  logic          io_in_2_valid,
    input  logic [W-1:0]  io_in_2_bits,
    input  logic          io_in_2_last,
    output logic          io_in_2_ready,
    input  logic          io_in_3_valid,
    input  logic [W-1:0]  io_in_3_bits,
    input  logic          io_in_3_last,
    output logic          io_in_3_ready,
    input  logic          io_out_ready,
    output logic          io_out_valid,
    output logic [W-1:0]  io_out_bits,
    output logic          io_out_last,
    output logic [IW-1:0] io_chosen,
    output logic          io_locked
);

    arb_state_e    state_q;
    logic [IW-1:0] lock_idx_q;
    logic [IW-1:0] last_grant_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_last;
    logic [W-1:0]  in_bits [N];
    logic [N-1:0]  in_ready;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] chosen;
    logic          grant_en;
    logic          fire;

    assign in_valid   = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
    assign in_last    = {io_in_3_last, io_in_2_last, io_in_1_last, io_in_0_last};
    assign in_bits[0] = io_in_0_bits;
    assign in_bits[1] = io_in_1_bits;
    assign in_bits[2] = io_in_2_bits;
    assign in_bits[3] = io_in_3_bits;

    rr_priority_pick u_pick (
        .valid_i      (in_valid),
        .last_grant_i (last_grant_q),
        .chosen_o     (pick_idx),
        .any_o        (pick_any)
    );

    // Handshake: a beat moves when io_out_valid && io_out_ready; the routed input's
    // ready mirrors io_out_ready, every other input sees ready=0, nothing moves in reset.
    always_comb begin
        chosen       = (state_q == LOCKED) ? lock_idx_q : pick_idx;
        grant_en     = !reset && ((state_q == LOCKED) || pick_any);
        io_out_valid = !reset && in_valid[chosen];
        io_out_bits  = in_bits[chosen];
        io_out_last  = in_last[chosen];
        for (int k = 0; k < N; k++) begin
            in_ready[k] = grant_en && io_out_ready && (IW'(k) == chosen);
        end
        fire    = io_out_valid && io_out_ready;
        count_d = count_q + CW'(1);
    end

    assign io_in_0_ready = in_ready[0];
    assign io_in_1_ready = in_ready[1];
    assign io_in_2_ready = in_ready[2];
    assign io_in_3_ready = in_ready[3];
    assign io_chosen     = chosen;
    assign io_locked     = (state_q == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lock_idx_q   <= '0;
            count_q      <= '0;
            last_grant_q <= '0;
        end else if (fire) begin
            case (state_q)
                IDLE: begin
                    last_grant_q <= chosen;
                    if (!io_out_last && (BURST > 1)) begin
                        state_q    <= LOCKED;
                        lock_idx_q <= chosen;
                        count_q    <= CW'(1);
                    end
                end
                LOCKED: begin
                    // Long packets are cut at BURST beats; the rest re-arbitrates.
                    if (io_out_last || (count_d == CW'(BURST))) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        count_q <= count_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
